fpnew_lane_iter_div: RTL and testbench

FPNEW_LANE_ITER_DIV -- requirements
Module: fpnew_lane_iter_div

---
 rtl/fpnew_lane_iter_div.sv | 162 ++++++++++++++++
 tb/tb_fpnew_lane_iter_div.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_lane_iter_div.sv
// Iterative restoring mantissa divider for one FP lane.
// Produces quot = floor(a * 2^(WIDTH+1) / b) (low QBITS bits) one bit per
// cycle, MSB first, plus a sticky bit for a nonzero remainder and a
// zero-divisor flag. Results live in dedicated output registers that only
// change on completion, on a zero-divisor start, or on reset.
module fpnew_lane_iter_div #(
    parameter  int unsigned WIDTH = 24,
    localparam int unsigned QBITS = WIDTH + 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fsm_start_i,
    input  logic             fsm_kill_i,
    input  logic             lane_en_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             fsm_ready_o,
    output logic             busy_o,
    output logic [QBITS-1:0] quot_o,
    output logic             sticky_o,
    output logic             div_zero_o
);

    localparam int unsigned    CW       = $clog2(QBITS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(QBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               lsb_q, lsb_d;
    logic [QBITS-1:0]   work_q, work_d;
    logic [QBITS-1:0]   quot_q, quot_d;
    logic               sticky_q, sticky_d;
    logic               dz_q, dz_d;

    logic               div_is_zero_s;
    logic [WIDTH-1:0]   half_s;
    logic [WIDTH:0]     rem_init_s;
    logic [WIDTH:0]     trial_s;
    logic               ge_s;
    logic [WIDTH:0]     rem_step_s;
    logic [QBITS-1:0]   qword_s;

    // Start-time preparation and one restoring-division step.
    // Quotient bits above the kept window come from floor(a/2) / b; only the
    // remainder of that part matters for the kept bits, so the iteration is
    // seeded with floor(a/2) mod b and the dividend LSB is shifted in on the
    // first step. The remainder then always stays below b.
    always_comb begin
        div_is_zero_s = (divisor_i == {WIDTH{1'b0}});
        half_s        = {1'b0, dividend_i[WIDTH-1:1]};
        if (div_is_zero_s) begin
            rem_init_s = {(WIDTH+1){1'b0}};
        end else begin
            rem_init_s = {1'b0, half_s % divisor_i};
        end
        trial_s = {rem_q[WIDTH-1:0], (cnt_q == {CW{1'b0}}) ? lsb_q : 1'b0};
        ge_s    = (trial_s >= {1'b0, div_q});
        if (ge_s) begin
            rem_step_s = trial_s - {1'b0, div_q};
        end else begin
            rem_step_s = trial_s;
        end
        qword_s = {work_q[QBITS-2:0], ge_s};
    end

    // Next-state and datapath next values; kill beats start, start beats iteration.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        div_d    = div_q;
        lsb_d    = lsb_q;
        work_d   = work_q;
        quot_d   = quot_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        if (fsm_kill_i) begin
            state_d = IDLE;
        end else if (fsm_start_i) begin
            div_d  = divisor_i;
            lsb_d  = dividend_i[0];
            rem_d  = rem_init_s;
            cnt_d  = {CW{1'b0}};
            work_d = {QBITS{1'b0}};
            if (!lane_en_i) begin
                state_d = DONE;
            end else if (div_is_zero_s) begin
                state_d  = DONE;
                quot_d   = {QBITS{1'b1}};
                sticky_d = 1'b0;
                dz_d     = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    rem_d  = rem_step_s;
                    work_d = qword_s;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DONE;
                        quot_d   = qword_s;
                        sticky_d = (rem_step_s != {(WIDTH+1){1'b0}});
                        dz_d     = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            rem_q    <= {(WIDTH+1){1'b0}};
            div_q    <= {WIDTH{1'b0}};
            lsb_q    <= 1'b0;
            work_q   <= {QBITS{1'b0}};
            quot_q   <= {QBITS{1'b0}};
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            lsb_q    <= lsb_d;
            work_q   <= work_d;
            quot_q   <= quot_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
        end
    end

    assign fsm_ready_o = (state_q == DONE);
    assign busy_o      = (state_q == RUN);
    assign quot_o      = quot_q;
    assign sticky_o    = sticky_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_fpnew_lane_iter_div.sv
// Directed and randomized bench for fpnew_lane_iter_div at WIDTH=8.
module tb_fpnew_lane_iter_div;

    localparam int W  = 8;
    localparam int QB = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          kill;
    logic          en;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          busy;
    logic [QB-1:0] quot;
    logic          sticky;
    logic          dz;

    int checks = 0;
    int errors = 0;

    fpnew_lane_iter_div #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .fsm_start_i (start),
        .fsm_kill_i  (kill),
        .lane_en_i   (en),
        .dividend_i  (a),
        .divisor_i   (b),
        .fsm_ready_o (ready),
        .busy_o      (busy),
        .quot_o      (quot),
        .sticky_o    (sticky),
        .div_zero_o  (dz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; afterwards scramble operands to show they are ignored.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ev);
        a = av; b = bv; en = ev; start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); en = 1'($urandom);
    endtask

    // Called in cycle 1 after a start; returns the cycle index where ready rose (bounded).
    task automatic run_to_done(output int cyc);
        cyc = 1;
        while (!ready && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    // Reference: quotient and sticky straight from the arithmetic definition.
    task automatic ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                           output logic [QB-1:0] q, output logic s);
        logic [63:0] num;
        logic [63:0] full;
        num  = 64'(av) * (64'd1 << (W + 1));
        full = num / 64'(bv);
        q    = full[QB-1:0];
        s    = ((num % 64'(bv)) != 64'd0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0]  ra, rb;
        logic [QB-1:0] eq;
        logic          es;

        rst = 1'b1; start = 1'b0; kill = 1'b0; en = 1'b0; a = '0; b = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_quot", 32'(quot), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        step();
        chk("idle_hold", 32'(ready | busy), 32'd0);

        // Computed result, exact
        start_op(8'hC0, 8'h80, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_ready", 32'(ready), 32'd0);
            step();
        end
        chk("c11_ready", 32'(ready), 32'd1);
        chk("c11_busy", 32'(busy), 32'd0);
        chk("c0_quot", 32'(quot), 32'h300);
        chk("c0_sticky", 32'(sticky), 32'd0);
        chk("c0_dz", 32'(dz), 32'd0);
        step(); step(); step();
        chk("done_hold_ready", 32'(ready), 32'd1);
        chk("done_hold_quot", 32'(quot), 32'h300);

        // Remainder, then back-to-back restart from DONE
        start_op(8'h80, 8'hC0, 1'b1);
        run_to_done(cyc);
        chk("c1_lat", 32'(cyc), 32'd11);
        chk("c1_quot", 32'(quot), 32'h155);
        chk("c1_sticky", 32'(sticky), 32'd1);
        start_op(8'hFF, 8'hFF, 1'b1);
        chk("b2b_ready", 32'(ready), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        run_to_done(cyc);
        chk("c2_lat", 32'(cyc), 32'd11);
        chk("c2_quot", 32'(quot), 32'h200);
        chk("c2_sticky", 32'(sticky), 32'd0);

        // Zero divisor, then disabled lane
        start_op(8'h5A, 8'h00, 1'b1);
        chk("dz_ready", 32'(ready), 32'd1);
        chk("dz_quot", 32'(quot), 32'h3FF);
        chk("dz_sticky", 32'(sticky), 32'd0);
        chk("dz_flag", 32'(dz), 32'd1);
        start_op(8'hC0, 8'h80, 1'b0);
        chk("dis_ready", 32'(ready), 32'd1);
        chk("dis_quot", 32'(quot), 32'h3FF);
        chk("dis_dz", 32'(dz), 32'd1);
        start_op(8'h11, 8'h00, 1'b0);
        chk("dis0_quot", 32'(quot), 32'h3FF);

        // Kill in cycle 5 of RUN
        start_op(8'hC0, 8'h80, 1'b1);
        for (int c = 1; c < 5; c++) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_ready", 32'(ready), 32'd0);
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_quot", 32'(quot), 32'h3FF);
        chk("kill_dz", 32'(dz), 32'd1);
        // Kill together with start
        a = 8'hC0; b = 8'h80; en = 1'b1; start = 1'b1; kill = 1'b1;
        step();
        start = 1'b0; kill = 1'b0;
        chk("ks_busy", 32'(busy), 32'd0);
        chk("ks_ready", 32'(ready), 32'd0);
        for (int c = 0; c < 12; c++) step();
        chk("ks_idle", 32'(ready | busy), 32'd0);
        chk("ks_quot", 32'(quot), 32'h3FF);

        // Restart while in RUN
        start_op(8'hC0, 8'h80, 1'b1);
        step(); step();
        start_op(8'h80, 8'hC0, 1'b1);
        run_to_done(cyc);
        chk("rr_lat", 32'(cyc), 32'd11);
        chk("rr_quot", 32'(quot), 32'h155);
        chk("rr_sticky", 32'(sticky), 32'd1);

        // Kill in DONE keeps results
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kd_ready", 32'(ready), 32'd0);
        chk("kd_quot", 32'(quot), 32'h155);

        // Reset in cycle 4 of RUN
        start_op(8'hFF, 8'h01, 1'b1);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_ready", 32'(ready), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_quot", 32'(quot), 32'd0);
        chk("mr_sticky", 32'(sticky), 32'd0);
        chk("mr_dz", 32'(dz), 32'd0);
        // Reset with a simultaneous start (and kill)
        a = 8'h40; b = 8'h00; en = 1'b1; start = 1'b1; kill = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; kill = 1'b0;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_ready", 32'(ready), 32'd0);
        step();
        chk("rs_idle", 32'(ready | busy), 32'd0);
        chk("rs_dz", 32'(dz), 32'd0);

        // Random nonzero operand pairs, back-to-back
        for (int n = 0; n < 3000; n++) begin
            ra = W'($urandom_range(1, (1 << W) - 1));
            if (n % 2 == 0) rb = W'($urandom_range(1, (1 << W) - 1));
            else            rb = W'($urandom_range(1, 15));
            ref_div(ra, rb, eq, es);
            start_op(ra, rb, 1'b1);
            run_to_done(cyc);
            chk("rnd_lat", 32'(cyc), 32'd11);
            chk("rnd_quot", 32'(quot), 32'(eq));
            chk("rnd_sticky", 32'(sticky), 32'(es));
            chk("rnd_dz", 32'(dz), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
